// File: rtl/x1_out_misr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | x1_out_misr : MISR response compactor for the x1 block's 35-bit output.   |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module x1_out_misr #(
  parameter int                WIDTH = 35,
  parameter int                CNT_W = 16,
  parameter logic [WIDTH-1:0]  POLY  = 35'h0_0000_0005,
  parameter logic [WIDTH-1:0]  SEED  = 35'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             abort,
  input  logic [WIDTH-1:0] po_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sig,
  output logic             sig_valid,
  input  logic             sig_ack,
  output logic             busy,
  output logic [CNT_W-1:0] vec_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic [WIDTH-1:0] misr_next;

  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN);
  assign sig_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Shift toward the MSB; the bit shifted out selects the feedback taps.
  assign misr_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ po_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sig       <= SEED;
      vec_cnt   <= '0;
      remaining <= '0;
    end else if (abort) begin
      state     <= IDLE;
      sig       <= SEED;
      vec_cnt   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sig       <= SEED;
            vec_cnt   <= '0;
            remaining <= num_vec;
            state     <= (num_vec == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            sig       <= misr_next;
            vec_cnt   <= vec_cnt + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          // An ack takes precedence; a start here is simply dropped.
          if (sig_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_x1_out_misr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_x1_out_misr : scoreboard bench for x1_out_misr with a GF(2) model.     |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_x1_out_misr;
  localparam int          WIDTH = 35;
  localparam int          CNT_W = 16;
  localparam logic [34:0] POLY  = 35'h0_0000_0005;
  localparam logic [34:0] SEED  = 35'h0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] po_vec = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] sig;
  logic             sig_valid;
  logic             sig_ack = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] vec_cnt;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [34:0] s;
    logic [15:0] n;
  } exp_t;

  exp_t        exp_q[$];
  logic [34:0] cur_vecs[$];

  x1_out_misr #(.WIDTH(WIDTH), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .abort(abort),
    .po_vec(po_vec), .in_valid(in_valid), .in_ready(in_ready), .sig(sig),
    .sig_valid(sig_valid), .sig_ack(sig_ack), .busy(busy), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Signature as a polynomial: each vector multiplies by x modulo the
  // feedback polynomial, then adds the new vector.
  function automatic logic [34:0] fold(input logic [34:0] seed);
    longint unsigned s;
    s = 64'(seed);
    foreach (cur_vecs[i]) begin
      s = s * 2;
      if (s >= (64'd1 << 35)) s = (s - (64'd1 << 35)) ^ 64'(POLY);
      s = s ^ 64'(cur_vecs[i]);
    end
    return s[34:0];
  endfunction

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (sig_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_sig: got sig %0h with no run pending", sig);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sig", 64'(sig), 64'(e.s));
        check("vec_cnt", 64'(vec_cnt), 64'(e.n));
      end
    end
    prev_valid = sig_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_vec = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [34:0] v, input int gaps);
    logic [63:0] r;
    repeat (gaps) begin
      r = {$urandom, $urandom};
      in_valid = 1'b0;
      po_vec = r[34:0];
      step();
    end
    check("in_ready_run", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    po_vec = v;
    step();
    in_valid = 1'b0;
  endtask

  // Runs the vectors in cur_vecs; gap of -1 means a random gap up to 2.
  task automatic run(input int gap, input bit hold_valid, input bit start_mid);
    logic [34:0] want;
    int n;
    n = cur_vecs.size();
    want = fold(SEED);
    exp_q.push_back('{s: want, n: 16'(n)});
    do_start(n);
    foreach (cur_vecs[i]) begin
      if (start_mid && i == 1) begin
        start = 1'b1;
        num_vec = 16'd7;
        step();
        start = 1'b0;
      end
      send(cur_vecs[i], (gap < 0) ? $urandom_range(2, 0) : gap);
    end
    check("valid_latency", 64'(sig_valid), 64'd1);
    if (hold_valid) begin
      in_valid = 1'b1;
      po_vec = 35'h7_FFFF_FFFF;
      check("ready_in_done", 64'(in_ready), 64'd0);
      step();
      check("done_hold_cnt", 64'(vec_cnt), 64'(n));
      check("done_hold_sig", 64'(sig), 64'(want));
      in_valid = 1'b0;
    end
    sig_ack = 1'b1;
    step();
    sig_ack = 1'b0;
    check("valid_drop", 64'(sig_valid), 64'd0);
    check("sig_hold", 64'(sig), 64'(want));
  endtask

  task automatic fill_random(input int n);
    logic [63:0] r;
    cur_vecs.delete();
    for (int i = 0; i < n; i++) begin
      r = {$urandom, $urandom};
      cur_vecs.push_back(r[34:0]);
    end
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_sig", 64'(sig), 64'(SEED));
    check("rst_valid", 64'(sig_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(vec_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // in_valid while idle changes nothing.
    in_valid = 1'b1; po_vec = 35'h1234; step(); in_valid = 1'b0;
    check("idle_ignore", 64'(sig), 64'(SEED));

    cur_vecs = '{35'h1};
    run(0, 1'b0, 1'b0);
    check("t1_sig", 64'(sig), 64'h1);

    cur_vecs = '{35'h1, 35'h1};
    run(0, 1'b0, 1'b0);
    check("t2_sig", 64'(sig), 64'h3);

    cur_vecs = '{35'h4_0000_0000, 35'h0};
    run(0, 1'b0, 1'b0);
    check("t3_feedback", 64'(sig), 64'h5);

    fill_random(3);
    run(1, 1'b1, 1'b0);

    // Zero-length run completes immediately with the seed.
    cur_vecs.delete();
    exp_q.push_back('{s: SEED, n: 16'd0});
    do_start(0);
    check("zero_valid", 64'(sig_valid), 64'd1);
    check("zero_sig", 64'(sig), 64'(SEED));
    sig_ack = 1'b1; start = 1'b1; num_vec = 16'd3; step();
    sig_ack = 1'b0; start = 1'b0;
    check("ack_beats_start", 64'(busy), 64'd0);

    fill_random(2);
    run(0, 1'b0, 1'b1);

    // Abort mid-run, with a concurrent accept that must be discarded.
    fill_random(4);
    do_start(4);
    send(cur_vecs[0], 0);
    send(cur_vecs[1], 0);
    abort = 1'b1; in_valid = 1'b1; po_vec = cur_vecs[2]; step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sig", 64'(sig), 64'(SEED));
    check("abort_cnt", 64'(vec_cnt), 64'd0);
    check("abort_valid", 64'(sig_valid), 64'd0);
    cur_vecs = '{35'h7};
    run(0, 1'b0, 1'b0);
    check("after_abort", 64'(sig), 64'h7);

    // Asynchronous reset mid-run takes effect before the next edge.
    fill_random(4);
    cur_vecs[0] = cur_vecs[0] | 35'h1;
    do_start(4);
    send(cur_vecs[0], 0);
    send(cur_vecs[1], 0);
    rst_n = 1'b0;
    #1;
    check("arst_sig", 64'(sig), 64'(SEED));
    check("arst_cnt", 64'(vec_cnt), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    cur_vecs = '{35'h7};
    run(0, 1'b0, 1'b0);
    check("after_rst", 64'(sig), 64'h7);

    for (int k = 0; k < 10; k++) begin
      fill_random($urandom_range(8, 1));
      run(-1, k[0], 1'b0);
    end

    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
